imem_loader: RTL and testbench

- Write-side counterpart of the instruction memory. Accepts a byte stream from a host link (UART receiver or testbench driver) over a valid/ready handshake.
- Assembles bytes little-endian into 32-bit instruction words and writes them into the instruction memory write port at byte addresses 0, 4, 8, ...
- Holds the single-cycle core stalled until the program is complete. Replaces $readmemh preloading for on-FPGA program download.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_if.sv | 18 +
 rtl/imem_loader_packer.sv | 43 ++++
 rtl/imem_loader.sv | 116 +++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader
// and the core top that consumes its write port.
package imem_loader_pkg;

    localparam int ADDR_W         = 10;
    localparam int BYTES_PER_WORD = 4;
    localparam int MAX_WORDS      = (2 ** ADDR_W) / BYTES_PER_WORD;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } load_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake from the host link and the instruction memory write port.
interface byte_stream_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

interface imem_wr_if #(parameter int ADDR_W = 10);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;

    modport master (output we, output addr, output wdata);
    modport slave  (input we, input addr, input wdata);
endinterface

// File: rtl/imem_loader_packer.sv
// Little-endian byte-to-word packer: byte k of a word lands in bits [8k+7:8k].
module byte_to_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        wordReady_o
);

    logic [1:0]  byteIdx_q, byteIdx_d;
    logic [31:0] shift_q, shift_d;

    always_comb begin
        byteIdx_d = byteIdx_q;
        shift_d   = shift_q;
        if (clear_i) begin
            byteIdx_d = '0;
            shift_d   = '0;
        end else if (push_i) begin
            shift_d[8*byteIdx_q +: 8] = byte_i;
            byteIdx_d = byteIdx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byteIdx_q <= '0;
            shift_q   <= '0;
        end else begin
            byteIdx_q <= byteIdx_d;
            shift_q   <= shift_d;
        end
    end

    // The word is presented in the same cycle its final byte arrives.
    assign word_o      = shift_d;
    assign wordReady_o = push_i && !clear_i && (byteIdx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Downloads a program byte stream into instruction memory and holds the
// core in reset-like stall until the requested number of words is written.
module imem_loader #(
    parameter int ADDR_W    = imem_loader_pkg::ADDR_W,
    parameter int MAX_WORDS = imem_loader_pkg::MAX_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-2:0] word_count_i,
    byte_stream_if.slave      in_if,
    imem_wr_if.master         mem_if,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-2:0] words_loaded_o
);
    import imem_loader_pkg::*;

    localparam int CNT_W = ADDR_W - 1;

    load_state_e       state_q, state_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0]  wordsLoaded_q, wordsLoaded_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        packClear;
    logic        bytePush;
    logic        wordReady;
    logic [31:0] packWord;

    // Zero selects a full memory; oversized counts are clamped so the
    // address counter can never run past the top of memory.
    function automatic logic [CNT_W-1:0] targetFromCount(input logic [CNT_W-1:0] wc);
        if (wc == '0 || 32'(wc) > MAX_WORDS) begin
            return CNT_W'(MAX_WORDS);
        end
        return wc;
    endfunction

    assign bytePush = in_if.valid && in_if.ready;

    byte_to_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (packClear),
        .push_i     (bytePush),
        .byte_i     (in_if.data),
        .word_o     (packWord),
        .wordReady_o(wordReady)
    );

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        wordsLoaded_d = wordsLoaded_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        packClear     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d       = COLLECT;
                    target_d      = targetFromCount(word_count_i);
                    wordsLoaded_d = '0;
                    addr_d        = '0;
                    packClear     = 1'b1;
                end
            end
            COLLECT: begin
                if (wordReady) begin
                    wdata_d = packWord;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wordsLoaded_d = wordsLoaded_q + CNT_W'(1);
                // The address stays on the last word so it never wraps.
                if (wordsLoaded_d == target_q) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(BYTES_PER_WORD);
                    state_d = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            target_q      <= '0;
            wordsLoaded_q <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            wordsLoaded_q <= wordsLoaded_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
        end
    end

    assign in_if.ready    = (state_q == COLLECT);
    assign mem_if.we      = (state_q == WRITE);
    assign mem_if.addr    = addr_q;
    assign mem_if.wdata   = wdata_q;
    assign busy_o         = (state_q == COLLECT) || (state_q == WRITE);
    assign done_o         = (state_q == DONE);
    assign cpu_hold_o     = !((state_q == DONE) && !start_i);
    assign words_loaded_o = wordsLoaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives bytes at the falling edge and
// mirrors every memory write into a local image for read-back checks.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] wordCount;
    logic       cpuHold;
    logic       busy;
    logic       done;
    logic [8:0] wordsLoaded;

    int total = 0;
    int bad   = 0;

    logic [31:0] wrAddrQ[$];
    logic [31:0] wrDataQ[$];
    logic [31:0] modelMem [256];
    int          maxAddr;
    int          base;
    int          readyHits;

    byte_stream_if            inIf ();
    imem_wr_if #(.ADDR_W(10)) memIf ();

    imem_loader #(.ADDR_W(10), .MAX_WORDS(256)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start),
        .word_count_i  (wordCount),
        .in_if         (inIf.slave),
        .mem_if        (memIf.master),
        .cpu_hold_o    (cpuHold),
        .busy_o        (busy),
        .done_o        (done),
        .words_loaded_o(wordsLoaded)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Capture every write; a byte must never be offered as accepted during WRITE.
    always @(negedge clk) begin
        if (memIf.we === 1'b1) begin
            wrAddrQ.push_back(32'(memIf.addr));
            wrDataQ.push_back(memIf.wdata);
            modelMem[memIf.addr[9:2]] = memIf.wdata;
            if (int'(memIf.addr) > maxAddr) maxAddr = int'(memIf.addr);
            checkOutput("readyDuringWrite", 32'(inIf.ready), 32'd0);
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        logic accepted;
        accepted   = 1'b0;
        inIf.valid = 1'b0;
        repeat (gap) @(negedge clk);
        inIf.valid = 1'b1;
        inIf.data  = b;
        for (int i = 0; i < 64; i++) begin
            if (inIf.ready === 1'b1) begin
                accepted = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        inIf.valid = 1'b0;
        if (!accepted) checkOutput("byteAccepted", 32'(accepted), 32'd1);
    endtask

    task automatic sendWord(input logic [31:0] w, input int maxGap);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(w[8*k +: 8], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
        end
    endtask

    task automatic startLoad(input logic [8:0] wc);
        start     = 1'b1;
        wordCount = wc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".inReady"}, 32'(inIf.ready), 32'd0);
        checkOutput({tag, ".memWe"}, 32'(memIf.we), 32'd0);
        checkOutput({tag, ".memAddr"}, 32'(memIf.addr), 32'd0);
        checkOutput({tag, ".memWdata"}, memIf.wdata, 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".done"}, 32'(done), 32'd0);
        checkOutput({tag, ".wordsLoaded"}, 32'(wordsLoaded), 32'd0);
        checkOutput({tag, ".cpuHold"}, 32'(cpuHold), 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        wordCount  = '0;
        inIf.valid = 1'b0;
        inIf.data  = '0;
        maxAddr    = 0;
        readyHits  = 0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single word, back-to-back bytes.
        startLoad(9'd1);
        checkOutput("t1.busy", 32'(busy), 32'd1);
        sendWord(32'h0010_0513, 0);
        waitDone("t1.done");
        checkOutput("t1.writes", 32'(wrAddrQ.size()), 32'd1);
        checkOutput("t1.addr", wrAddrQ[0], 32'd0);
        checkOutput("t1.data", wrDataQ[0], 32'h0010_0513);
        checkOutput("t1.cpuHold", 32'(cpuHold), 32'd0);
        checkOutput("t1.busy0", 32'(busy), 32'd0);
        checkOutput("t1.wordsLoaded", 32'(wordsLoaded), 32'd1);
        checkOutput("t1.wdataHeld", memIf.wdata, 32'h0010_0513);

        // Three words with random valid gaps; hold must reassert as start is seen.
        start     = 1'b1;
        wordCount = 9'd3;
        #1;
        checkOutput("t2.holdOnStart", 32'(cpuHold), 32'd1);
        @(negedge clk);
        start = 1'b0;
        checkOutput("t2.doneCleared", 32'(done), 32'd0);
        base = wrAddrQ.size();
        sendWord(32'h1122_3344, 3);
        sendWord(32'hA5A5_0F0F, 3);
        sendWord(32'hDEAD_BEEF, 3);
        waitDone("t2.done");
        checkOutput("t2.writes", 32'(wrAddrQ.size() - base), 32'd3);
        checkOutput("t2.addr0", wrAddrQ[base], 32'd0);
        checkOutput("t2.addr1", wrAddrQ[base+1], 32'd4);
        checkOutput("t2.addr2", wrAddrQ[base+2], 32'd8);
        checkOutput("t2.data0", wrDataQ[base], 32'h1122_3344);
        checkOutput("t2.data1", wrDataQ[base+1], 32'hA5A5_0F0F);
        checkOutput("t2.data2", wrDataQ[base+2], 32'hDEAD_BEEF);
        checkOutput("t2.wordsLoaded", 32'(wordsLoaded), 32'd3);

        // A start mid-collection must not restart the session.
        startLoad(9'd2);
        base = wrAddrQ.size();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h02, 0);
        startLoad(9'd7);
        checkOutput("t3.busyAfterStart", 32'(busy), 32'd1);
        applyStimulus(8'h03, 1);
        applyStimulus(8'h04, 0);
        sendWord(32'h8765_4321, 2);
        waitDone("t3.done");
        checkOutput("t3.wordsLoaded", 32'(wordsLoaded), 32'd2);
        checkOutput("t3.writes", 32'(wrAddrQ.size() - base), 32'd2);
        checkOutput("t3.data0", wrDataQ[base], 32'h0403_0201);
        checkOutput("t3.addr1", wrAddrQ[base+1], 32'd4);
        checkOutput("t3.data1", wrDataQ[base+1], 32'h8765_4321);

        // Bytes offered in DONE are never taken.
        base       = wrAddrQ.size();
        inIf.valid = 1'b1;
        inIf.data  = 8'h77;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (inIf.ready !== 1'b0) readyHits++;
        end
        inIf.valid = 1'b0;
        checkOutput("t3.readyInDone", 32'(readyHits), 32'd0);
        checkOutput("t3.noWritesInDone", 32'(wrAddrQ.size() - base), 32'd0);
        checkOutput("t3.stillDone", 32'(done), 32'd1);

        // Full memory: word_count 0 means 256 words.
        maxAddr = 0;
        base    = wrAddrQ.size();
        startLoad(9'd0);
        for (int i = 0; i < 256; i++) sendWord(32'(i), 0);
        waitDone("t4.done");
        checkOutput("t4.writes", 32'(wrAddrQ.size() - base), 32'd256);
        checkOutput("t4.lastAddr", wrAddrQ[wrAddrQ.size()-1], 32'd1020);
        checkOutput("t4.lastData", wrDataQ[wrDataQ.size()-1], 32'h0000_00FF);
        checkOutput("t4.maxAddr", 32'(maxAddr), 32'd1020);
        checkOutput("t4.wordsLoaded", 32'(wordsLoaded), 32'd256);
        checkOutput("t4.mem100", modelMem[100], 32'd100);

        // 43-word program, read back word by word as the pc would fetch it.
        for (int i = 0; i < 256; i++) modelMem[i] = 32'hDEAD_DEAD;
        startLoad(9'd43);
        for (int i = 0; i < 43; i++) sendWord((32'(i) << 20) | 32'h0000_0093, 1);
        waitDone("t5.done");
        for (int i = 0; i < 43; i++) begin
            checkOutput($sformatf("t5.pc%0d", i * 4), modelMem[i], (32'(i) << 20) | 32'h0000_0093);
        end
        checkOutput("t5.beyondProgram", modelMem[43], 32'hDEAD_DEAD);

        // Reset partway through word 5 discards it and returns to reset values.
        startLoad(9'd8);
        base = wrAddrQ.size();
        for (int i = 0; i < 5; i++) sendWord(32'h5000_0000 + 32'(i), 0);
        applyStimulus(8'hAA, 0);
        applyStimulus(8'hBB, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkResetValues("t6");
        inIf.valid = 1'b1;
        inIf.data  = 8'hCC;
        repeat (8) @(negedge clk);
        inIf.valid = 1'b0;
        checkOutput("t6.writes", 32'(wrAddrQ.size() - base), 32'd5);
        startLoad(9'd1);
        sendWord(32'hCAFE_F00D, 0);
        waitDone("t6.reloadDone");
        checkOutput("t6.reloadAddr", wrAddrQ[wrAddrQ.size()-1], 32'd0);
        checkOutput("t6.reloadData", wrDataQ[wrDataQ.size()-1], 32'hCAFE_F00D);
        checkOutput("t6.reloadWrites", 32'(wrAddrQ.size() - base), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
